adder_arbiter: RTL and testbench

Shares one combinational prefix adder (stage1..stage5 + sum) between two requesters: port 0 = integer ALU, port 1 = address generator.
- Round-robin arbitration with an optional lock for multi-word (carry-chained) sequences.
- Two-stage pipeline: operand register, then result register.
- valid/ready handshakes on both sides.
- Sits in RTL/alu between the issue logic and the shared adder instance.

---
 rtl/adder_arbiter_pkg.sv | 28 ++
 rtl/adder_arbiter_rr_arb2.sv | 30 +++
 rtl/adder_arbiter.sv | 178 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: widths, FSM state encoding and requester indices shared
// by the adder arbiter and its round-robin picker.
// LEN_DATA may be supplied by the build; the datapath is LEN_DATA+1 bits wide.

`ifndef LEN_DATA
`define LEN_DATA 31
`endif

package adder_arbiter_pkg;

   localparam int ADDER_W     = `LEN_DATA + 1;
   localparam int ADDER_TAG_W = 4;

   typedef enum logic {
      ARB_S_ARB  = 1'b0,
      ARB_S_LOCK = 1'b1
   } arb_state_e;

   // Requester indices: port 0 is the integer ALU, port 1 the address generator.
   localparam logic ARB_REQ_ALU = 1'b0;
   localparam logic ARB_REQ_AGU = 1'b1;

   // Index to one-hot grant vector.
   function automatic logic [1:0] onehot2(input logic idx);
      return (idx == ARB_REQ_AGU) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/adder_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker. While a lock is held only the lock
// owner can be granted; otherwise a sole requester wins, and on contention the
// requester that did not win last time (i_rr) wins.

module rr_arb2
   import adder_arbiter_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_rr,
   input  logic       i_lock_en,
   input  logic       i_lock_id,
   output logic [1:0] o_grant
);

   // Select at most one requester.
   always_comb begin
      // NOTE: default first so every path assigns o_grant and no latch is inferred.
      o_grant = 2'b00;
      if (i_lock_en) begin
         if (i_valid[i_lock_id]) o_grant = onehot2(i_lock_id);
      end else begin
         case (i_valid)
            2'b01, 2'b10: o_grant = i_valid;
            2'b11:        o_grant = onehot2((i_rr == ARB_REQ_ALU) ? ARB_REQ_AGU : ARB_REQ_ALU);
            default:      o_grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one external combinational adder between the integer
// ALU (port 0) and the address generator (port 1). Round-robin arbitration
// with an optional lock for carry-chained multi-word sequences, an operand
// register (stage 1) driving the adder and a result register (stage 2).
// Optional build macro ADDER_ARB_SUB_EN adds req_sub: subtract beats drive
// add_b = ~b and force carry-in 1 unless chained (borrow chain via carry_q).

module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter int W     = ADDER_W,
   parameter int TAG_W = ADDER_TAG_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [1:0]         req_lock,
   input  logic [1:0]         req_chain,
   input  logic [1:0]         req_cin,
`ifdef ADDER_ARB_SUB_EN
   input  logic [1:0]         req_sub,
`endif
   input  logic [2*W-1:0]     req_a,
   input  logic [2*W-1:0]     req_b,
   input  logic [2*TAG_W-1:0] req_tag,
   output logic [W-1:0]       add_a,
   output logic [W-1:0]       add_b,
   output logic               add_cin,
   input  logic [W-1:0]       add_sum,
   input  logic               add_cout,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [W-1:0]       rsp_sum,
   output logic               rsp_cout,
   output logic               rsp_id,
   output logic [TAG_W-1:0]   rsp_tag
);

   arb_state_e       r_state;
   logic             r_lock_id;
   logic             r_rr;

   logic             r_op_valid;
   logic [W-1:0]     r_op_a;
   logic [W-1:0]     r_op_b;
   logic             r_op_cin;
   logic             r_op_chain;
   logic             r_op_id;
   logic [TAG_W-1:0] r_op_tag;
`ifdef ADDER_ARB_SUB_EN
   logic             r_op_sub;
`endif
   logic             r_carry;

   logic             r_rsp_valid;
   logic [W-1:0]     r_rsp_sum;
   logic             r_rsp_cout;
   logic             r_rsp_id;
   logic [TAG_W-1:0] r_rsp_tag;

   logic [1:0]       w_grant;
   logic             w_s2_load;
   logic             w_s1_adv;
   logic             w_s1_open;
   logic             w_accept;
   logic             w_gid;

   rr_arb2 u_pick (
      .i_valid   (req_valid),
      .i_rr      (r_rr),
      .i_lock_en (r_state == ARB_S_LOCK),
      .i_lock_id (r_lock_id),
      .o_grant   (w_grant)
   );

   assign w_s2_load = !r_rsp_valid || rsp_ready;
   assign w_s1_adv  = r_op_valid && w_s2_load;
   assign w_s1_open = !r_op_valid || w_s1_adv;
   assign req_ready = (rst || !w_s1_open) ? 2'b00 : w_grant;
   assign w_accept  = |(req_valid & req_ready);
   assign w_gid     = req_ready[1];

   // carry_q is written on the same edge a beat leaves stage 1, so a chained
   // follower accepted on that edge already sees its predecessor's carry-out
   // when it reaches stage 1; back-to-back chaining needs no extra bypass.
   assign add_a = r_op_a;
`ifdef ADDER_ARB_SUB_EN
   assign add_b   = r_op_sub ? ~r_op_b : r_op_b;
   assign add_cin = r_op_chain ? r_carry : (r_op_sub | r_op_cin);
`else
   assign add_b   = r_op_b;
   assign add_cin = r_op_chain ? r_carry : r_op_cin;
`endif

   // Arbitration FSM: round-robin pointer and lock ownership.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
         r_state   <= ARB_S_ARB;
         r_lock_id <= 1'b0;
         r_rr      <= 1'b0;
      end else if (w_accept) begin
         r_rr <= w_gid;
         case (r_state)
            ARB_S_ARB: begin
               if (req_lock[w_gid]) begin
                  r_state   <= ARB_S_LOCK;
                  r_lock_id <= w_gid;
               end
            end
            ARB_S_LOCK: begin
               if (!req_lock[w_gid]) r_state <= ARB_S_ARB;
            end
         endcase
      end
   end

   // Stage 1: capture the granted request's operands; record carry on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: payload registers are cleared too so nothing stale is visible after reset.
         r_op_valid <= 1'b0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_cin   <= 1'b0;
         r_op_chain <= 1'b0;
         r_op_id    <= 1'b0;
         r_op_tag   <= '0;
`ifdef ADDER_ARB_SUB_EN
         r_op_sub   <= 1'b0;
`endif
         r_carry    <= 1'b0;
      end else begin
         if (w_s1_adv) r_carry <= add_cout;
         if (w_s1_open) begin
            r_op_valid <= w_accept;
            if (w_accept) begin
               r_op_a     <= w_gid ? req_a[2*W-1:W] : req_a[W-1:0];
               r_op_b     <= w_gid ? req_b[2*W-1:W] : req_b[W-1:0];
               r_op_cin   <= req_cin[w_gid];
               r_op_chain <= req_chain[w_gid];
               r_op_id    <= w_gid;
               r_op_tag   <= w_gid ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
`ifdef ADDER_ARB_SUB_EN
               r_op_sub   <= req_sub[w_gid];
`endif
            end
         end
      end
   end

   // Stage 2: register the adder result whenever the output slot is free.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_cout  <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_tag   <= '0;
      end else if (w_s2_load) begin
         r_rsp_valid <= r_op_valid;
         if (r_op_valid) begin
            r_rsp_sum  <= add_sum;
            r_rsp_cout <= add_cout;
            r_rsp_id   <= r_op_id;
            r_rsp_tag  <= r_op_tag;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_sum   = r_rsp_sum;
   assign rsp_cout  = r_rsp_cout;
   assign rsp_id    = r_rsp_id;
   assign rsp_tag   = r_rsp_tag;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors for the adder arbiter. Accepted requests
// push their hand-computed result into a scoreboard queue; a monitor pops and
// compares whenever a response handshake occurs. The shared adder is modelled
// here as a plain W-bit add with carry.

module tb_adder_arbiter;
   import adder_arbiter_pkg::*;

   localparam int W     = ADDER_W;
   localparam int TAG_W = ADDER_TAG_W;

   typedef struct {
      logic [W-1:0]     sum;
      logic             cout;
      logic             id;
      logic [TAG_W-1:0] tag;
      int               acc_cyc;
      bit               chk_lat;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [1:0]         req_valid = '0;
   logic [1:0]         req_ready;
   logic [1:0]         req_lock = '0;
   logic [1:0]         req_chain = '0;
   logic [1:0]         req_cin = '0;
`ifdef ADDER_ARB_SUB_EN
   logic [1:0]         req_sub = '0;
`endif
   logic [2*W-1:0]     req_a = '0;
   logic [2*W-1:0]     req_b = '0;
   logic [2*TAG_W-1:0] req_tag = '0;
   logic [W-1:0]       add_a, add_b, add_sum;
   logic               add_cin, add_cout;
   logic               rsp_valid;
   logic               rsp_ready = 1'b1;
   logic [W-1:0]       rsp_sum;
   logic               rsp_cout;
   logic               rsp_id;
   logic [TAG_W-1:0]   rsp_tag;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   exp_t pend [2];
   exp_t sb_q [$];
   int   grant_log [$];

   adder_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lock  (req_lock),
      .req_chain (req_chain),
      .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
      .req_sub   (req_sub),
`endif
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id),
      .rsp_tag   (rsp_tag)
   );

   // External shared adder.
   logic [W:0] full_sum;
   assign full_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
   assign add_sum  = full_sum[W-1:0];
   assign add_cout = full_sum[W];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Accept watcher: every request handshake pushes its expected response.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int r = 0; r < 2; r++) begin
            if (req_valid[r] && req_ready[r]) begin
               e = pend[r];
               e.acc_cyc = cyc;
               sb_q.push_back(e);
               grant_log.push_back(r);
               acc_cnt++;
            end
         end
         if (req_valid == 2'b11) check("ready_onehot", {63'd0, req_ready == 2'b11}, 64'd0);
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d tag 0x%0h sum 0x%0h, expected no response", rsp_id, rsp_tag, rsp_sum);
         end else begin
            e = sb_q.pop_front();
            check("rsp_sum", rsp_sum, e.sum);
            check("rsp_cout", rsp_cout, e.cout);
            check("rsp_id", rsp_id, e.id);
            check("rsp_tag", rsp_tag, e.tag);
            if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
         end
      end
   end

   task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic chain, input logic lock, input logic sub,
                          input logic [TAG_W-1:0] tag, input logic [W-1:0] esum,
                          input logic ecout, input bit lat);
      exp_t e;
      e.sum = esum;
      e.cout = ecout;
      e.id = (r == 1);
      e.tag = tag;
      e.acc_cyc = 0;
      e.chk_lat = lat;
      pend[r] = e;
      req_a[r*W +: W] = a;
      req_b[r*W +: W] = b;
      req_tag[r*TAG_W +: TAG_W] = tag;
      req_cin[r] = cin;
      req_chain[r] = chain;
      req_lock[r] = lock;
`ifdef ADDER_ARB_SUB_EN
      req_sub[r] = sub;
`else
      if (sub) $display("note: subtract beat ignored in this build");
`endif
   endtask

   task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic chain, input logic lock, input logic sub,
                       input logic [TAG_W-1:0] tag, input logic [W-1:0] esum,
                       input logic ecout, input bit lat);
      int n;
      set_req(r, a, b, cin, chain, lock, sub, tag, esum, ecout, lat);
      req_valid[r] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[r] && n < 64);
      if (!req_ready[r]) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: requester %0d got no grant in %0d cycles, expected a grant", r, n);
      end
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
      req_lock[r]  = 1'b0;
      req_chain[r] = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("drain_empty", sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_grants(input string name, input int g0, input int g1, input int g2);
      check({name, "_count"}, grant_log.size(), 3);
      check(name, grant_log[0], g0);
      check(name, grant_log[1], g1);
      check(name, grant_log[2], g2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int exp_g [4];
      int acc0;
      exp_g = '{1, 0, 1, 0};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_req_ready", req_ready, 2'b00);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_reset_rsp_valid", rsp_valid, 1'b0);
      check("post_reset_rsp_sum", rsp_sum, 0);
      check("post_reset_rsp_cout", rsp_cout, 1'b0);
      check("post_reset_rsp_id", rsp_id, 1'b0);
      check("post_reset_rsp_tag", rsp_tag, 0);
      @(posedge clk);
      #1;

      // Single request on the ALU port: 5 + 7 = 12.
      send(0, 5, 7, 0, 0, 0, 0, 4'hA, 12, 0, 1);
      wait_drain();

      // Contention: rr = 0, so grants go 1,0,1,0.
      grant_log.delete();
      fork
         begin
            send(0, 1, 2, 0, 0, 0, 0, 4'h1, 3, 0, 1);
            send(0, 'h10, 'h20, 0, 0, 0, 0, 4'h2, 'h30, 0, 1);
         end
         begin
            send(1, 'h8000_0000, 'h8000_0000, 0, 0, 0, 0, 4'h3, 0, 1, 1);
            send(1, 7, 8, 1, 0, 0, 0, 4'h4, 16, 0, 1);
         end
      join
      check("contention_count", grant_log.size(), 4);
      for (int i = 0; i < 4; i++) check("contention_order", grant_log[i], exp_g[i]);
      wait_drain();

      // Locked carry chain on the AGU port, back to back; ALU held off.
      grant_log.delete();
      fork
         begin
            send(1, 'hFFFF_FFFF, 1, 0, 0, 1, 0, 4'h5, 0, 1, 1);
            send(1, 0, 0, 0, 1, 0, 0, 4'h6, 1, 0, 1);
         end
         send(0, 2, 2, 0, 0, 0, 0, 4'h7, 4, 0, 1);
      join
      check_grants("lock_order", 1, 1, 0);
      wait_drain();

      // Lock owner drops valid for a while: lock persists, carry is kept.
      grant_log.delete();
      fork
         begin
            send(1, 'hFFFF_FFFF, 'hFFFF_FFFF, 1, 0, 1, 0, 4'h8, 'hFFFF_FFFF, 1, 1);
            repeat (3) @(posedge clk);
            #1;
            send(1, 1, 1, 0, 1, 0, 0, 4'h9, 3, 0, 1);
         end
         send(0, 9, 9, 0, 0, 0, 0, 4'hB, 18, 0, 1);
      join
      check_grants("lock_gap_order", 1, 1, 0);
      wait_drain();

      // Backpressure: three-cycle stall admits exactly two beats.
      acc0 = acc_cnt;
      rsp_ready = 1'b0;
      fork
         begin
            send(0, 1, 1, 0, 0, 0, 0, 4'hC, 2, 0, 0);
            send(0, 2, 2, 0, 0, 0, 0, 4'hD, 4, 0, 0);
            send(0, 3, 3, 0, 0, 0, 0, 4'hE, 6, 0, 0);
         end
         begin
            repeat (3) @(negedge clk);
            @(posedge clk);
            check("bp_accepts", acc_cnt - acc0, 2);
            #1 rsp_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset in LOCK(0) with both stages full.
      rsp_ready = 1'b0;
      send(0, 1, 0, 0, 0, 1, 0, 4'h1, 1, 0, 0);
      send(0, 2, 0, 0, 0, 1, 0, 4'h2, 2, 0, 0);
      set_req(0, 100, 1, 0, 0, 0, 0, 4'hF, 101, 0, 1);
      set_req(1, 3, 4, 0, 0, 0, 0, 4'h9, 7, 0, 1);
      req_valid = 2'b11;
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("rst_mid_lock_ready", req_ready, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_lock_rsp_valid", rsp_valid, 1'b0);
      check("rst_mid_lock_grant", req_ready, 2'b10);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      @(negedge clk);
      check("rst_next_grant", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      wait_drain();

`ifdef ADDER_ARB_SUB_EN
      // Subtract: 10 - 3 = 7 with carry-out 1 (no borrow).
      send(0, 10, 3, 0, 0, 0, 1, 4'h5, 7, 1, 1);
      wait_drain();
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
